// File: rtl/ca_code_gen_pkg.sv
// ca_code_gen_pkg: shared C/A code constants, LFSR taps and PRN key table
package ca_code_gen_pkg;
  localparam int CA_CHIPS = 1023;
  localparam int SLEW_W = 11;
  localparam logic [9:0] CA_G1_INIT = 10'h3FF;
  localparam logic [9:0] CA_G2_INIT = 10'h000;
  localparam logic [9:0] CA_G1_TAPS = 10'h081;
  localparam logic [9:0] CA_G2_TAPS = 10'h197;
  localparam logic [9:0] CA_PRN_KEY [1:2] = '{10'h3EC, 10'h3D8};
  typedef logic [SLEW_W-1:0] slew_t;
  typedef logic [10:0] code_phase_t;
endpackage

// File: rtl/ca_code_gen_if.sv
// ca_code_gen_if: channel-side control inputs and replica outputs of the C/A generator
//   master: drives hc_enable, prn_key(_enable), code_slew, slew_enable, tic_enable
//   slave : drives early, prompt, late, fc_enable, dump_enable, code_phase
interface ca_code_gen_if;
  import ca_code_gen_pkg::*;
  logic hc_enable;
  logic [9:0] prn_key;
  logic prn_key_enable;
  slew_t code_slew;
  logic slew_enable;
  logic tic_enable;
  logic early;
  logic prompt;
  logic late;
  logic fc_enable;
  logic dump_enable;
  code_phase_t code_phase;
  modport master(output hc_enable, prn_key, prn_key_enable, code_slew, slew_enable, tic_enable,
                 input early, prompt, late, fc_enable, dump_enable, code_phase);
  modport slave(input hc_enable, prn_key, prn_key_enable, code_slew, slew_enable, tic_enable,
                output early, prompt, late, fc_enable, dump_enable, code_phase);
endinterface

// File: rtl/ca_code_gen_lfsr10.sv
// ca_lfsr10: 10-stage Fibonacci LFSR, shifting right, feedback = parity of tapped bits
//   i_load/i_load_val: parallel load (wins over shift); i_shift: advance one chip
//   o_bit: stage 10 (bit 0)
module ca_lfsr10 #(
  parameter logic [9:0] TAPS = 10'h081,
  parameter logic [9:0] RST_VAL = 10'h3FF
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       i_load,
  input  logic [9:0] i_load_val,
  input  logic       i_shift,
  output logic       o_bit
);
  logic [9:0] r_q;
  always_ff @(posedge clk or posedge rst)
    if (rst) r_q <= RST_VAL;
    else r_q <= i_load ? i_load_val : i_shift ? {^(r_q & TAPS), r_q[9:1]} : r_q;
  assign o_bit = r_q[0];
endmodule

// File: rtl/ca_code_gen.sv
// ca_code_gen: per-channel C/A replica generator with E/P/L taps, epoch dump, slew and TIC latch
//   clk, rst (async, active high)
//   bus (slave): hc_enable, prn_key, prn_key_enable, code_slew, slew_enable, tic_enable in;
//                early, prompt, late, fc_enable, dump_enable, code_phase out
module ca_code_gen
  import ca_code_gen_pkg::*;
#(
  parameter int CHIPS_PER_EPOCH = CA_CHIPS
) (
  input logic clk,
  input logic rst,
  ca_code_gen_if.slave bus
);
  logic [9:0] r_chip;
  logic r_hc;
  logic [2:0] r_srq;
  slew_t r_slew_cnt, r_slew_reg;
  logic r_pend, r_fc, r_dump;
  code_phase_t r_cp;
  logic w_g1, w_g2, w_adv, w_chip_adv, w_epoch, w_load;
  assign w_adv = bus.hc_enable && r_slew_cnt == '0;
  assign w_chip_adv = w_adv && r_hc;
  assign w_epoch = w_chip_adv && r_chip == 10'(CHIPS_PER_EPOCH - 1);
  // Reloading at every epoch pins the code to chip 0 without relying on LFSR period.
  assign w_load = bus.prn_key_enable || w_epoch;
  ca_lfsr10 #(.TAPS(CA_G1_TAPS), .RST_VAL(CA_G1_INIT)) u_g1 (
    .clk(clk), .rst(rst), .i_load(w_load), .i_load_val(CA_G1_INIT),
    .i_shift(w_chip_adv), .o_bit(w_g1)
  );
  ca_lfsr10 #(.TAPS(CA_G2_TAPS), .RST_VAL(CA_G2_INIT)) u_g2 (
    .clk(clk), .rst(rst), .i_load(w_load), .i_load_val(bus.prn_key),
    .i_shift(w_chip_adv), .o_bit(w_g2)
  );
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      r_chip <= '0;
      r_hc <= 1'b0;
      r_srq <= '0;
      r_slew_cnt <= '0;
      r_slew_reg <= '0;
      r_pend <= 1'b0;
      r_fc <= 1'b0;
      r_dump <= 1'b0;
      r_cp <= '0;
    end else begin
      r_fc <= w_chip_adv && !bus.prn_key_enable;
      r_dump <= w_epoch && !bus.prn_key_enable;
      if (bus.tic_enable) r_cp <= {r_chip, r_hc};
      if (bus.prn_key_enable) begin
        r_chip <= '0;
        r_hc <= 1'b0;
        r_srq <= '0;
        r_slew_cnt <= '0;
        r_pend <= 1'b0;
      end else begin
        if (bus.hc_enable && r_slew_cnt != '0) r_slew_cnt <= r_slew_cnt - 1'b1;
        if (w_adv) begin
          r_srq <= {r_srq[1:0], w_g1 ^ w_g2};
          r_hc <= !r_hc;
        end
        if (w_chip_adv) r_chip <= w_epoch ? '0 : r_chip + 10'd1;
        // The pending flag is sampled before this cycle's slew_enable, so a
        // slew written on the epoch cycle waits for the following epoch.
        if (w_epoch && r_pend) begin
          r_slew_cnt <= r_slew_reg;
          r_pend <= 1'b0;
        end
        if (bus.slew_enable) begin
          r_slew_reg <= bus.code_slew;
          r_pend <= 1'b1;
        end
      end
    end
  assign bus.early = r_srq[0];
  assign bus.prompt = r_srq[1];
  assign bus.late = r_srq[2];
  assign bus.fc_enable = r_fc;
  assign bus.dump_enable = r_dump;
  assign bus.code_phase = r_cp;
endmodule

// File: tb/tb_ca_code_gen.sv
// tb_ca_code_gen: directed scenarios plus random traffic against a half-chip-stream reference model
module tb_ca_code_gen;
  import ca_code_gen_pkg::*;
  logic clk = 1'b0;
  logic rst = 1'b1;
  ca_code_gen_if bus();
  ca_code_gen dut(.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;
  int errors = 0, checks = 0;
  bit m_code [1023];
  logic [9:0] m_key;
  int m_pos, m_hold, m_slew_reg;
  bit m_pend, m_fc, m_dump;
  logic [2:0] m_srq;
  logic [10:0] m_cp;
  int n_dump = 0, n_fc = 0, fc_at_dump = 0;
  logic [31:0] e_hist = '0;
  task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask
  task automatic build(logic [9:0] key);
    int s1 [1:10];
    int s2 [1:10];
    int f1, f2;
    for (int k = 1; k <= 10; k++) begin
      s1[k] = 1;
      s2[k] = int'(key[10-k]);
    end
    for (int c = 0; c < 1023; c++) begin
      m_code[c] = bit'(s1[10] ^ s2[10]);
      f1 = s1[3] ^ s1[10];
      f2 = s2[2] ^ s2[3] ^ s2[6] ^ s2[8] ^ s2[9] ^ s2[10];
      for (int k = 10; k >= 2; k--) begin
        s1[k] = s1[k-1];
        s2[k] = s2[k-1];
      end
      s1[1] = f1;
      s2[1] = f2;
    end
    m_key = key;
  endtask
  task automatic model_reset();
    build(10'h000);
    m_pos = 0; m_hold = 0; m_slew_reg = 0; m_pend = 0;
    m_fc = 0; m_dump = 0; m_srq = '0; m_cp = '0;
  endtask
  task automatic model(bit hc, bit pke, bit se, logic [10:0] slew, bit tic);
    bit pend_old;
    pend_old = m_pend;
    m_fc = 0;
    m_dump = 0;
    if (tic) m_cp = 11'(m_pos);
    if (pke) begin
      if (bus.prn_key != m_key) build(bus.prn_key);
      m_pos = 0; m_srq = '0; m_hold = 0; m_pend = 0;
    end else begin
      if (hc) begin
        if (m_hold > 0) m_hold--;
        else begin
          m_srq = {m_srq[1:0], m_code[m_pos/2]};
          if (m_pos % 2 == 1) m_fc = 1;
          m_pos++;
          if (m_pos == 2046) begin
            m_pos = 0;
            m_dump = 1;
            if (bus.prn_key != m_key) build(bus.prn_key);
            if (pend_old) begin
              m_hold = m_slew_reg;
              m_pend = 0;
            end
          end
        end
      end
      if (se) begin
        m_slew_reg = int'(slew);
        m_pend = 1;
      end
    end
  endtask
  task automatic step(bit hc = 0, bit pke = 0, bit se = 0, logic [10:0] slew = '0, bit tic = 0);
    bus.hc_enable = hc;
    bus.prn_key_enable = pke;
    bus.slew_enable = se;
    bus.code_slew = slew;
    bus.tic_enable = tic;
    @(posedge clk);
    model(hc, pke, se, slew, tic);
    #1;
    check("outs", {16'h0, bus.early, bus.prompt, bus.late, bus.fc_enable, bus.dump_enable, bus.code_phase},
          {16'h0, m_srq[0], m_srq[1], m_srq[2], m_fc, m_dump, m_cp});
    if (bus.fc_enable) n_fc++;
    if (bus.dump_enable) begin
      n_dump++;
      fc_at_dump = n_fc;
    end
    if (hc) e_hist = {e_hist[30:0], bus.early};
    bus.hc_enable = 0; bus.prn_key_enable = 0; bus.slew_enable = 0; bus.code_slew = '0; bus.tic_enable = 0;
  endtask
  task automatic run_hc(int n);
    repeat (n) begin
      step(1);
      step(0);
    end
  endtask
  task automatic to_dump(output int cnt);
    int prev;
    prev = n_dump;
    cnt = 0;
    while (n_dump == prev && cnt < 4200) begin
      step(1);
      step(0);
      cnt++;
    end
    if (n_dump == prev) check("dump_timeout", 0, 1);
  endtask
  task automatic scen1();
    logic [9:0] pv, lv;
    step(0, 0, 0, '0, 1);
    check("tic_rst", 32'(bus.code_phase), 0);
    check("rst_outs", {bus.early, bus.prompt, bus.late, bus.fc_enable, bus.dump_enable}, 0);
    bus.prn_key = CA_PRN_KEY[1];
    step(0, 1);
    pv = '0;
    lv = '0;
    for (int n = 1; n <= 21; n++) begin
      step(1);
      if (n % 2 == 0) pv = {pv[8:0], bus.prompt};
      if (n % 2 == 1 && n >= 3) lv = {lv[8:0], bus.late};
      repeat (19) step(0);
    end
    check("prn1_prompt", 32'(pv), 32'h320);
    check("prn1_late", 32'(lv), 32'h320);
  endtask
  initial begin
    int c;
    logic [31:0] a;
    bit pke;
    bus.hc_enable = 0; bus.prn_key = '0; bus.prn_key_enable = 0;
    bus.code_slew = '0; bus.slew_enable = 0; bus.tic_enable = 0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check("rst_hold", {bus.early, bus.prompt, bus.late, bus.fc_enable, bus.dump_enable, bus.code_phase}, 0);
    rst = 0;
    scen1();
    step(0, 1);
    n_dump = 0;
    n_fc = 0;
    run_hc(32);
    a = e_hist;
    run_hc(2014);
    check("ep_dumps", n_dump, 1);
    check("ep_fc", fc_at_dump, 1023);
    run_hc(32);
    check("ep_repeat", e_hist, a);
    step(0, 1);
    run_hc(500);
    step(0, 0, 1, 11'd5);
    to_dump(c);
    to_dump(c);
    check("slew_per", c, 2051);
    run_hc(2045);
    c = n_dump;
    step(1, 0, 1, 11'd7);
    check("epoch_se_dump", n_dump - c, 1);
    step(0);
    to_dump(c);
    check("defer1", c, 2046);
    to_dump(c);
    check("defer2", c, 2053);
    step(0, 1);
    run_hc(35);
    step(1, 0, 0, '0, 1);
    check("tic17", 32'(bus.code_phase), 32'({10'd17, 1'b1}));
    step(0, 0, 1, 11'd9);
    to_dump(c);
    run_hc(2);
    step(1, 1);
    check("pke_fc", {bus.fc_enable, bus.dump_enable}, 0);
    step(0, 0, 0, '0, 1);
    check("pke_chip", 32'(bus.code_phase), 0);
    step(1);
    check("pke_early", bus.early, 1);
    run_hc(300);
    #3 rst = 1;
    #1;
    check("async_rst", {bus.early, bus.prompt, bus.late, bus.fc_enable, bus.dump_enable, bus.code_phase}, 0);
    model_reset();
    @(posedge clk);
    #1 rst = 0;
    scen1();
    for (int i = 0; i < 12000; i++) begin
      pke = $urandom_range(0, 2999) == 0;
      if (pke) bus.prn_key = $urandom_range(0, 1) ? 10'h3D8 : 10'($urandom);
      step(1'($urandom_range(0, 1)), pke, $urandom_range(0, 299) == 0,
           11'($urandom_range(0, 20)), !pke && $urandom_range(0, 19) == 0);
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
